// File: rtl/adder_serial_seq.sv
// Nibble-serial 16-bit add/subtract: one 4-bit adder slice reused LSB-first over
// NIBBLES cycles, with the inter-nibble carry held in a register and a start/done handshake.

module adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module adder_serial_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   X,
  input  logic [4*NIBBLES-1:0]   Y,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   Z,
  output logic                   sign,
  output logic                   zero,
  output logic                   carry,
  output logic                   parity,
  output logic                   overflow
);
  localparam int W     = 4 * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cin;
  logic [W-1:0]       r_opa;
  logic [W-1:0]       r_opb;
  logic [W-1:0]       r_partial;
  logic [W-1:0]       r_z;
  logic               r_done;
  logic               r_sign;
  logic               r_zero;
  logic               r_carry;
  logic               r_parity;
  logic               r_overflow;

  logic [3:0]         w_a_nib;
  logic [3:0]         w_b_nib;
  logic [3:0]         w_sum;
  logic               w_cout;
  logic [W-1:0]       w_result;

  function automatic logic f_parity(input logic [W-1:0] v);
    return ~^v;
  endfunction

  // Overflow is judged on the effective second operand (already inverted for sub).
  function automatic logic f_overflow(input logic a_msb, input logic b_msb, input logic z_msb);
    return (a_msb & b_msb & ~z_msb) | (~a_msb & ~b_msb & z_msb);
  endfunction

  assign w_a_nib = r_opa[{r_cnt, 2'b00} +: 4];
  assign w_b_nib = r_opb[{r_cnt, 2'b00} +: 4];

  adder_4bit u_slice (
    .a    (w_a_nib),
    .b    (w_b_nib),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Partial sum with the current pass's nibble already merged in.
  always_comb begin
    w_result = r_partial;
    w_result[{r_cnt, 2'b00} +: 4] = w_sum;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cin      <= 1'b0;
      r_opa      <= '0;
      r_opb      <= '0;
      r_partial  <= '0;
      r_z        <= '0;
      r_done     <= 1'b0;
      r_sign     <= 1'b0;
      r_zero     <= 1'b0;
      r_carry    <= 1'b0;
      r_parity   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_opa     <= X;
            r_opb     <= sub ? ~Y : Y;
            r_cin     <= sub;
            r_cnt     <= '0;
            r_partial <= '0;
            r_state   <= CALC;
          end
        end
        CALC: begin
          r_partial <= w_result;
          r_cin     <= w_cout;
          if (r_cnt == LAST) begin
            r_z        <= w_result;
            r_carry    <= w_cout;
            r_sign     <= w_result[W-1];
            r_zero     <= (w_result == '0);
            r_parity   <= f_parity(w_result);
            r_overflow <= f_overflow(r_opa[W-1], r_opb[W-1], w_result[W-1]);
            r_done     <= 1'b1;
            r_cnt      <= '0;
            r_state    <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = (r_state == CALC);
  assign done     = r_done;
  assign Z        = r_z;
  assign sign     = r_sign;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign parity   = r_parity;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_adder_serial_seq.sv
// Self-checking bench for adder_serial_seq: directed cases plus random operations
// compared against a plain-arithmetic 17-bit reference model.

module tb_adder_serial_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] X;
  logic [15:0] Y;
  logic        busy;
  logic        done;
  logic [15:0] Z;
  logic        sign;
  logic        zero;
  logic        carry;
  logic        parity;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_z = 16'h0000;

  adder_serial_seq #(.NIBBLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .X        (X),
    .Y        (Y),
    .busy     (busy),
    .done     (done),
    .Z        (Z),
    .sign     (sign),
    .zero     (zero),
    .carry    (carry),
    .parity   (parity),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request and let it be captured at the next edge; returns #1 after it.
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic s);
    X = x; Y = y; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  // Wait for done, expecting it after exp_edges more edges; Z must hold meanwhile.
  task automatic wait_done(input int exp_edges);
    int n;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done) begin
        n = i;
        break;
      end
      chk("z_hold", {16'd0, Z}, {16'd0, last_z});
    end
    chk("latency", n, exp_edges);
  endtask

  task automatic check_result(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [15:0] b;
    logic [16:0] full;
    logic [15:0] z;
    logic        ov;
    b    = s ? ~y : y;
    full = {1'b0, x} + {1'b0, b} + {16'd0, s};
    z    = full[15:0];
    ov   = (x[15] == b[15]) && (z[15] != x[15]);
    chk("Z",        {16'd0, Z},        {16'd0, z});
    chk("carry",    {31'd0, carry},    {31'd0, full[16]});
    chk("sign",     {31'd0, sign},     {31'd0, z[15]});
    chk("zero",     {31'd0, zero},     {31'd0, (z == 16'd0)});
    chk("parity",   {31'd0, parity},   {31'd0, ~^z});
    chk("overflow", {31'd0, overflow}, {31'd0, ov});
    chk("done",     {31'd0, done},     32'd1);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    last_z = z;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s);
    start_op(x, y, s);
    wait_done(4);
    check_result(x, y, s);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; X = 16'h0; Y = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_flags", {26'd0, Z == 16'd0, sign, zero, carry, parity, overflow}, 32'h20);
    rst = 1'b0;

    run_op(16'h1234, 16'h4321, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1);
    run_op(16'h8000, 16'h0001, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b1);

    // Start during busy must be ignored.
    start_op(16'h1111, 16'h2222, 1'b0);
    X = 16'hABCD; Y = 16'h9999; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(2);
    check_result(16'h1111, 16'h2222, 1'b0);

    // Back-to-back: new request issued in the done cycle.
    start_op(16'h0010, 16'h0020, 1'b0);
    wait_done(4);
    check_result(16'h0010, 16'h0020, 1'b0);

    // Abort mid-operation; Z is nonzero beforehand so clearing is observable.
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_Z", {16'd0, Z}, 32'd0);
    chk("abort_flags", {27'd0, sign, zero, carry, parity, overflow}, 32'd0);
    last_z = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    run_op(16'h0001, 16'h0001, 1'b0);

    // Random operations, sometimes issued back-to-back from the done cycle.
    for (int i = 0; i < 40; i++) begin
      logic [15:0] rx, ry;
      logic        rs;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rs = 1'($urandom);
      if (($urandom % 4) == 0) begin
        rx = {rx[15], 15'h7FFF};
        ry = rs ? ~rx : {1'b0, ry[14:0]};
      end
      start_op(rx, ry, rs);
      wait_done(4);
      check_result(rx, ry, rs);
      if ($urandom % 2) begin
        @(posedge clk); #1;
        chk("done_pulse_rand", {31'd0, done}, 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adder_serial_seq.md
Name: adder_serial_seq

Overview:
- Nibble-serial sequencer for the 16-bit add/subtract datapath with a start/done handshake.
- Instantiates one existing adder_4bit slice (sum, cout, a, b, cin) and reuses it over 4 cycles, LSB nibble first, with the carry held in a register between passes.
- Produces the same result and flags as the combinational 16-bit adder (sign, zero, carry, parity, overflow) at about a quarter of the adder area.
- Sits between a control FSM/CPU decode stage and the register file.

Parameters:
- NIBBLES, 4, number of 4-bit passes per operation (fixed; operand width = 4*NIBBLES = 16).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- start  input  1  request an operation; sampled only when busy=0
- sub  input  1  0: Z=X+Y; 1: Z=X-Y (X + ~Y + 1); captured with start
- X  input  16  operand A, captured with start
- Y  input  16  operand B, captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Z and flags are updated
- Z  output  16  result, registered
- sign  output  1  Z[15]
- zero  output  1  1 when Z==0
- carry  output  1  carry out of bit 15 (raw, not inverted to borrow for sub)
- parity  output  1  even parity: ~^Z
- overflow  output  1  signed overflow, computed on the effective second operand

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; pass counter=0; carry register=0; operand and partial-sum registers=0.
  - Outputs after reset: busy=0, done=0, Z=0, sign=0, zero=0, carry=0, parity=0, overflow=0.
  - rst has priority over every other input.
- FSM has two states, IDLE and CALC.
- IDLE behaviour:
  - If start=1, capture X into opA.
  - Capture opB = sub ? ~Y : Y.
  - Set cin_reg = sub; cnt=0; go to CALC.
  - If start=0, stay in IDLE and hold all outputs.
- CALC behaviour, each cycle:
  - The slice adds opA[4*cnt+3:4*cnt] + opB[same nibble] + cin_reg.
  - The 4-bit sum is written into partial[4*cnt+3:4*cnt].
  - cin_reg takes the slice cout.
  - cnt increments.
- On the CALC cycle with cnt=3:
  - Z is loaded with the full partial result, with the last nibble taken from the slice output that cycle.
  - carry is loaded with the slice cout.
  - sign, zero and parity are computed from the new Z.
  - overflow = (opA[15] & opB[15] & ~Z[15]) | (~opA[15] & ~opB[15] & Z[15]).
  - done=1 for exactly one cycle; state returns to IDLE; cnt returns to 0.
- Latency: start sampled at edge k gives done=1 and valid Z/flags after edge k+4. Throughput is one operation per 4 cycles.
- busy = (state==CALC). It is high from edge k through edge k+4.
- start while busy=1 is ignored. It is not queued and does not disturb the captured operands.
- Back-to-back operation: start may be asserted in the same cycle done=1, because state is already IDLE. The next operation is captured at that edge, and done rises again 4 edges later.
- Z and flags hold their last completed values during CALC. They change only on the done edge, never mid-operation.
- Reset during CALC: the operation is aborted, all outputs are cleared per reset values, and no done pulse is generated.
- Arithmetic wraps modulo 2^16.
- Subtract semantics:
  - carry=1 means no borrow.
  - 0-0 gives carry=1.

Test Plan:
- Reset, then add X=0x1234, Y=0x4321, sub=0 -> after 4 edges: done=1, Z=0x5555, carry=0, zero=0, sign=0, parity=1, overflow=0. busy is high for the 4 preceding cycles.
- X=0x7FFF, Y=0x0001, sub=0 -> Z=0x8000, sign=1, overflow=1, carry=0, parity=0, zero=0.
- X=0xFFFF, Y=0x0001, sub=0 -> Z=0x0000, carry=1, zero=1, parity=1, overflow=0. This checks the carry ripple through all 4 passes.
- X=0x0005, Y=0x0005, sub=1 -> Z=0x0000, carry=1, zero=1. Then X=0x8000, Y=0x0001, sub=1 -> Z=0x7FFF, overflow=1, sign=0, carry=1.
- Busy and back-to-back handling:
  - Assert start with new operands during busy -> ignored, result matches the first operands.
  - Assert start in the done cycle with X=0x0010, Y=0x0020 -> second done exactly 4 edges later with Z=0x0030.
- Mid-operation reset:
  - Assert rst at the 2nd CALC cycle -> next cycle busy=0, Z=0, all flags 0, no done pulse.
  - A following add of 0x0001+0x0001 must give Z=0x0002, with no stale carry from the aborted operation.
